// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

    localparam int OB_DEPTH = 2;

    typedef logic [1:0] ob_cnt_t;

    // True when a new read still fits in the output buffer after this cycle's pop.
    function automatic logic ob_room(
        input ob_cnt_t ob_cnt,
        input logic    inflight,
        input logic    pop
    );
        logic [2:0] occ;
        occ = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(OB_DEPTH);
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_out_buffer.sv
// Two-entry register FIFO holding RAM read data ahead of the consumer.
module fifo_out_buffer
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  valid_o,
    output ob_cnt_t               count_o
);

    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;
    ob_cnt_t               cnt_q, cnt_d;
    logic                  pop;
    logic                  push;

    assign pop  = pop_i && (cnt_q != 2'd0);
    assign push = push_i && ((cnt_q != 2'(OB_DEPTH)) || pop);

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    e0_d = din_i;
                end else begin
                    e1_d = din_i;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Full buffer shifts; a single entry is simply replaced.
                if (cnt_q == 2'(OB_DEPTH)) begin
                    e0_d = e1_q;
                    e1_d = din_i;
                end else begin
                    e0_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o  = e0_q;
    assign valid_o = (cnt_q != 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller wrapping an external 1-cycle-latency
// simple dual-port RAM, with a 2-entry output buffer for full throughput.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [DATA_WIDTH-1:0] enq_bits,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [DATA_WIDTH-1:0] deq_bits,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int CW = ADDR_WIDTH + 2;
    localparam int RW = ADDR_WIDTH + 1;
    localparam logic [RW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [RW-1:0]         ram_cnt_q, ram_cnt_d;
    logic                  rd_inflight_q;
    logic                  enq_fire;
    logic                  deq_fire;
    logic                  read_issue;
    ob_cnt_t               ob_cnt;

    assign enq_ready = (ram_cnt_q != DEPTH);
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    // Reads only see committed entries, so no same-cycle write hazard.
    assign read_issue = (ram_cnt_q != '0)
                     && ob_room(ob_cnt, rd_inflight_q, deq_fire);

    assign ram_wen   = enq_fire;
    assign ram_waddr = wptr_q;
    assign ram_din   = enq_bits;
    assign ram_ren   = read_issue;
    assign ram_raddr = rptr_q;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q + RW'(enq_fire) - RW'(read_issue);
        if (enq_fire) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (read_issue) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= read_issue;
        end
    end

    fifo_out_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ob (
        .clk_i  (clock),
        .rst_ni (reset),
        .push_i (rd_inflight_q),
        .din_i  (ram_dout),
        .pop_i  (deq_ready),
        .dout_o (deq_bits),
        .valid_o(deq_valid),
        .count_o(ob_cnt)
    );

    assign count = CW'(ram_cnt_q) + CW'(rd_inflight_q) + CW'(ob_cnt);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and scoreboard bench for ram_fifo_ctrl with a behavioural RAM.
module tb_ram_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          enq_valid;
    logic          enq_ready;
    logic [DW-1:0] enq_bits;
    logic          deq_valid;
    logic          deq_ready;
    logic [DW-1:0] deq_bits;
    logic [AW+1:0] count;
    logic          ram_wen;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_din;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [2**AW];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ram_fifo_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .enq_bits (enq_bits),
        .deq_valid(deq_valid),
        .deq_ready(deq_ready),
        .deq_bits (deq_bits),
        .count    (count),
        .ram_wen  (ram_wen),
        .ram_waddr(ram_waddr),
        .ram_din  (ram_din),
        .ram_ren  (ram_ren),
        .ram_raddr(ram_raddr),
        .ram_dout (ram_dout)
    );

    // Simple dual-port RAM, registered read, array not cleared by reset.
    always @(posedge clock) begin
        if (ram_wen) mem[ram_waddr] <= ram_din;
        if (ram_ren) ram_dout <= mem[ram_raddr];
    end

    typedef struct {
        logic          ev;
        logic [DW-1:0] eb;
        logic          dr;
        logic          x_er;
        logic          x_dv;
        logic [DW-1:0] x_db;
        logic          c_db;
        logic [AW+1:0] x_cnt;
        logic          x_ren;
        logic [AW-1:0] x_ra;
        logic          x_wen;
        logic [AW-1:0] x_wa;
    } vec_t;

    vec_t vec [14];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    logic [DW-1:0] sb [$];
    int acc, idx, sent, recv, first_cyc, viol;
    bit just18, started;
    int ob_tb, infl_tb;
    bit dfire;

    initial begin
        reset     = 1'b0;
        enq_valid = 1'b0;
        enq_bits  = '0;
        deq_ready = 1'b0;
        ram_dout  = '0;
        tick();
        tick();
        reset = 1'b1;

        // ev eb dr | er dv db cdb cnt ren ra wen wa
        vec[0]  = '{0, 0,     0, 1, 0, 0,     1, 0, 0, 0, 0, 0};
        vec[1]  = '{1, 'hA5,  0, 1, 0, 0,     1, 0, 0, 0, 1, 0};
        vec[2]  = '{0, 0,     0, 1, 0, 0,     1, 1, 1, 0, 0, 0};
        vec[3]  = '{0, 0,     0, 1, 0, 0,     1, 1, 0, 0, 0, 0};
        vec[4]  = '{0, 0,     0, 1, 1, 'hA5,  1, 1, 0, 0, 0, 0};
        vec[5]  = '{0, 0,     1, 1, 1, 'hA5,  1, 1, 0, 0, 0, 0};
        vec[6]  = '{0, 0,     1, 1, 0, 0,     0, 0, 0, 0, 0, 0};
        vec[7]  = '{1, 'h11,  1, 1, 0, 0,     0, 0, 0, 0, 1, 1};
        vec[8]  = '{1, 'h22,  1, 1, 0, 0,     0, 1, 1, 1, 1, 2};
        vec[9]  = '{1, 'h33,  1, 1, 0, 0,     0, 2, 1, 2, 1, 3};
        vec[10] = '{0, 0,     1, 1, 1, 'h11,  1, 3, 1, 3, 0, 0};
        vec[11] = '{0, 0,     1, 1, 1, 'h22,  1, 2, 0, 0, 0, 0};
        vec[12] = '{0, 0,     1, 1, 1, 'h33,  1, 1, 0, 0, 0, 0};
        vec[13] = '{0, 0,     1, 1, 0, 0,     0, 0, 0, 0, 0, 0};

        for (int k = 0; k < 14; k++) begin
            enq_valid = vec[k].ev;
            enq_bits  = vec[k].eb;
            deq_ready = vec[k].dr;
            @(negedge clock);
            chk($sformatf("v%0d_enq_ready", k), enq_ready, vec[k].x_er);
            chk($sformatf("v%0d_deq_valid", k), deq_valid, vec[k].x_dv);
            if (vec[k].c_db)
                chk($sformatf("v%0d_deq_bits", k), deq_bits, vec[k].x_db);
            chk($sformatf("v%0d_count", k), count, vec[k].x_cnt);
            chk($sformatf("v%0d_ram_ren", k), ram_ren, vec[k].x_ren);
            if (vec[k].x_ren)
                chk($sformatf("v%0d_ram_raddr", k), ram_raddr, vec[k].x_ra);
            chk($sformatf("v%0d_ram_wen", k), ram_wen, vec[k].x_wen);
            if (vec[k].x_wen) begin
                chk($sformatf("v%0d_ram_waddr", k), ram_waddr, vec[k].x_wa);
                chk($sformatf("v%0d_ram_din", k), ram_din, vec[k].eb);
            end
            tick();
        end

        // Fill with consumer stalled.
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        idx = 0;
        acc = 0;
        just18 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            enq_bits = DW'(idx);
            @(negedge clock);
            if (just18) chk("fill_ready_fall", enq_ready, 0);
            just18 = 1'b0;
            if (enq_ready) begin
                acc++;
                idx++;
                if (acc == 18) just18 = 1'b1;
            end
            tick();
        end
        enq_valid = 1'b0;
        @(negedge clock);
        chk("fill_accepted", DW'(acc), 18);
        chk("fill_enq_ready", enq_ready, 0);
        chk("fill_count", count, 18);
        chk("fill_deq_valid", deq_valid, 1);
        chk("fill_deq_bits", deq_bits, 0);
        tick();

        // Drain in order, one per cycle.
        deq_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            chk($sformatf("drain%0d_valid", i), deq_valid, 1);
            chk($sformatf("drain%0d_bits", i), deq_bits, DW'(i));
            if (i == 0) chk("drain_ready_low", enq_ready, 0);
            if (i == 1) chk("drain_ready_back", enq_ready, 1);
            tick();
        end
        @(negedge clock);
        chk("drain_empty_valid", deq_valid, 0);
        chk("drain_empty_count", count, 0);
        tick();

        // Streaming with both sides ready.
        sb.delete();
        sent = 0;
        recv = 0;
        started = 1'b0;
        first_cyc = -1;
        deq_ready = 1'b1;
        for (int c = 0; c < 400 && recv < 100; c++) begin
            enq_valid = (sent < 100);
            enq_bits  = 64'h1000 + DW'(sent);
            @(negedge clock);
            if (enq_valid && enq_ready) begin
                sb.push_back(enq_bits);
                sent++;
            end
            if (started) chk("stream_no_bubble", deq_valid, 1);
            if (deq_valid) begin
                if (!started) first_cyc = c;
                started = 1'b1;
                if (sb.size() == 0) chk("stream_sb_empty", deq_bits, '1);
                else chk("stream_data", deq_bits, sb.pop_front());
                recv++;
            end
            tick();
        end
        enq_valid = 1'b0;
        chk("stream_recv", DW'(recv), 100);
        chk("stream_latency", DW'(first_cyc), 3);

        // Random consumer stalls against a scoreboard and an occupancy model.
        sb.delete();
        sent = 0;
        recv = 0;
        viol = 0;
        ob_tb = 0;
        infl_tb = 0;
        for (int c = 0; c < 10000 && recv < 1000; c++) begin
            enq_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            enq_bits  = 64'h5000_0000 + DW'(sent);
            deq_ready = $urandom_range(0, 1) == 1;
            @(negedge clock);
            chk("rand_count", count, DW'(sb.size()));
            chk("rand_deq_valid", deq_valid, ob_tb > 0);
            dfire = deq_valid && deq_ready;
            if (ram_ren && (ob_tb + infl_tb - int'(dfire) >= 2)) viol++;
            if (enq_valid && enq_ready) begin
                sb.push_back(enq_bits);
                sent++;
            end
            if (dfire) begin
                if (sb.size() == 0) chk("rand_sb_empty", deq_bits, '1);
                else chk("rand_data", deq_bits, sb.pop_front());
                recv++;
            end
            ob_tb = ob_tb + infl_tb - int'(dfire);
            infl_tb = int'(ram_ren);
            tick();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        chk("rand_recv", DW'(recv), 1000);
        chk("rand_ren_overrun", DW'(viol), 0);

        // Reset while a read is in flight.
        for (int i = 0; i < 7; i++) begin
            enq_valid = 1'b1;
            enq_bits  = 64'h7000 + DW'(i);
            tick();
        end
        enq_bits  = 64'h7007;
        deq_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        @(negedge clock);
        chk("rst_pre_count", count, 7);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_count", count, 0);
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_deq_bits", deq_bits, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clock);
            chk($sformatf("rst_quiet%0d", i), deq_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
